// File: rtl/countdown_pkg.sv
// ----------------------------------------------------------------------------
// countdown_pkg
// Shared types and helpers for the multi-digit countdown timer.
//   state_t   : timer control state (IDLE, RUN, PAUSE, DONE)
//   sat_digit : clamps a preset digit into the legal range 0..radix-1
// ----------------------------------------------------------------------------
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Preset digits outside the radix are clamped to the largest legal digit.
  function automatic int unsigned sat_digit(input int unsigned value,
                                            input int unsigned radix);
    return (value >= radix) ? (radix - 1) : value;
  endfunction

endpackage

// File: rtl/n_down_counter.sv
// ----------------------------------------------------------------------------
// n_down_counter
// One radix-RADIX digit of the countdown chain. Decrements on i_count and
// wraps 0 -> RADIX-1, raising o_bo so the next digit up takes the borrow.
// Ports:
//   i_clock  : clock, rising edge
//   i_reset  : asynchronous reset, active-high (digit -> 0)
//   i_clear  : synchronous clear to 0 (highest priority)
//   i_load   : synchronous load of i_d (already range-limited by the parent)
//   i_d      : digit preset
//   i_count  : decrement request (borrow in)
//   o_bo     : borrow out = i_count & (digit == 0)
//   o_q      : current digit value
// ----------------------------------------------------------------------------
module n_down_counter
  import countdown_pkg::*;
#(
  parameter int unsigned  RADIX = 10,
  localparam int unsigned WIDTH = $clog2(RADIX)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_count,
  output logic             o_bo,
  output logic [WIDTH-1:0] o_q
);

  localparam logic [WIDTH-1:0] MaxDigit = WIDTH'(RADIX - 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;

  always_comb begin
    w_q_nxt = r_q;
    if (i_clear) begin
      w_q_nxt = '0;
    end else if (i_load) begin
      w_q_nxt = i_d;
    end else if (i_count) begin
      w_q_nxt = (r_q == '0) ? MaxDigit : (r_q - WIDTH'(1));
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign o_bo = i_count & (r_q == '0);
  assign o_q  = r_q;

endmodule

// File: rtl/n_countdown_timer.sv
// ----------------------------------------------------------------------------
// n_countdown_timer
// Multi-digit radix-RADIX countdown timer. A preset is loaded, the timer is
// started, and each i_count tick while running decrements the value. Reaching
// zero moves to DONE and pulses o_done for one cycle.
//
// Optional feature (macro COUNTDOWN_AUTO_RELOAD_EN): the terminal tick reloads
// the last loaded preset and keeps running instead of stopping, provided that
// preset is nonzero. o_done still pulses once per expiry.
//
// Ports:
//   i_clock      : clock, rising edge
//   i_reset      : asynchronous reset, active-high
//   i_clear      : synchronous clear to zero / IDLE (preset kept)
//   i_load       : synchronous load of i_load_value, goes to IDLE
//   i_load_value : preset, digit i at [i*WIDTH +: WIDTH]
//   i_start      : start / resume request
//   i_stop       : pause request (wins over i_start)
//   i_count      : one-cycle decrement tick
//   o_q          : current digits, same packing as i_load_value
//   o_running    : high while in RUN
//   o_zero       : all digits zero (combinational)
//   o_done       : one-cycle registered pulse on expiry
// ----------------------------------------------------------------------------
module n_countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned  RADIX  = 10,
  parameter int unsigned  DIGITS = 2,
  localparam int unsigned WIDTH  = $clog2(RADIX),
  localparam int unsigned QW     = DIGITS * WIDTH
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic [QW-1:0] i_load_value,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_count,
  output logic [QW-1:0] o_q,
  output logic          o_running,
  output logic          o_zero,
  output logic          o_done
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic [QW-1:0] r_reload;

  logic [QW-1:0] w_q;
  logic [QW-1:0] w_sat;
  logic [QW-1:0] w_digit_d;
  logic          w_digit_load;
  logic          w_tick;
  logic          w_zero;
  logic          w_terminal;
  logic          w_underflow;
  logic          w_reload_now;

  // Range-limit each preset digit once; both the digits and the reload
  // register see the clamped value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_sat
    assign w_sat[g*WIDTH +: WIDTH] =
        WIDTH'(sat_digit(32'(i_load_value[g*WIDTH +: WIDTH]), RADIX));
  end

  // A tick only reaches the digits in RUN and when nothing of higher
  // priority (clear, load, stop) is being acted on this edge.
  assign w_tick     = (r_state == RUN) & i_count & ~i_clear & ~i_load & ~i_stop;
  assign w_zero     = (w_q == '0);
  assign w_terminal = (w_q == QW'(1));

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // A zero preset cannot be re-armed, so that case falls through to DONE.
  assign w_reload_now = w_tick & w_terminal & (r_reload != '0);
`else
  assign w_reload_now = 1'b0;
`endif

  assign w_digit_load = i_load | w_reload_now;
  assign w_digit_d    = i_load ? w_sat : r_reload;

  // Borrow chain: digit g decrements when the tick arrives and every lower
  // digit is already zero. Each stage has its own wires so the chain is a
  // plain combinational ripple, not a self-referencing vector.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic w_cin;
    logic w_bo;

    if (g == 0) begin : g_first
      assign w_cin = w_tick;
    end else begin : g_rest
      assign w_cin = g_digit[g-1].w_bo;
    end

    n_down_counter #(
      .RADIX (RADIX)
    ) u_digit (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_clear (i_clear),
      .i_load  (w_digit_load),
      .i_d     (w_digit_d[g*WIDTH +: WIDTH]),
      .i_count (w_cin),
      .o_bo    (w_bo),
      .o_q     (w_q[g*WIDTH +: WIDTH])
    );
  end

  // Borrow out of the top digit means a tick at zero; RUN is never held at
  // zero, but treat it as expiry so the timer can never wrap silently.
  assign w_underflow = g_digit[DIGITS-1].w_bo;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (i_clear || i_load) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, PAUSE: begin
          if (i_start && !i_stop) begin
            if (w_zero) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (i_stop) begin
            w_state_nxt = PAUSE;
          end else if (w_tick && (w_terminal || w_underflow)) begin
            w_done_nxt = 1'b1;
            if (!w_reload_now) begin
              w_state_nxt = DONE;
            end
          end
        end
        DONE: begin
          w_state_nxt = DONE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_done   <= 1'b0;
      r_reload <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (i_load && !i_clear) begin
        r_reload <= w_sat;
      end
    end
  end

  assign o_q       = w_q;
  assign o_running = (r_state == RUN);
  assign o_zero    = w_zero;
  assign o_done    = r_done;

endmodule

// File: tb/tb_n_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_n_countdown_timer
// Directed bench for two timer instances: RADIX=10/DIGITS=2 (unit 0) and
// RADIX=16/DIGITS=1 (unit 1). Each step drives inputs, queues the expected
// outputs, clocks once and compares the DUT against the queued entry.
// ----------------------------------------------------------------------------
module tb_n_countdown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Unit 0: decimal, two digits.
  logic       a_rst, a_clr, a_ld, a_st, a_sp, a_cn;
  logic [7:0] a_lv;
  logic [7:0] a_q;
  logic       a_run, a_zero, a_done;

  // Unit 1: hex, one digit.
  logic       b_rst, b_clr, b_ld, b_st, b_sp, b_cn;
  logic [3:0] b_lv;
  logic [3:0] b_q;
  logic       b_run, b_zero, b_done;

  n_countdown_timer #(
    .RADIX  (10),
    .DIGITS (2)
  ) u_dut10 (
    .i_clock      (clk),
    .i_reset      (a_rst),
    .i_clear      (a_clr),
    .i_load       (a_ld),
    .i_load_value (a_lv),
    .i_start      (a_st),
    .i_stop       (a_sp),
    .i_count      (a_cn),
    .o_q          (a_q),
    .o_running    (a_run),
    .o_zero       (a_zero),
    .o_done       (a_done)
  );

  n_countdown_timer #(
    .RADIX  (16),
    .DIGITS (1)
  ) u_dut16 (
    .i_clock      (clk),
    .i_reset      (b_rst),
    .i_clear      (b_clr),
    .i_load       (b_ld),
    .i_load_value (b_lv),
    .i_start      (b_st),
    .i_stop       (b_sp),
    .i_count      (b_cn),
    .o_q          (b_q),
    .o_running    (b_run),
    .o_zero       (b_zero),
    .o_done       (b_done)
  );

  typedef struct {
    bit         unit;
    string      tag;
    logic [7:0] q;
    logic       run;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  task automatic push_exp(input bit unit, input string tag, input logic [7:0] q,
                          input logic run, input logic done);
    exp_t e;
    e.unit = unit;
    e.tag  = tag;
    e.q    = q;
    e.run  = run;
    e.done = done;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [7:0] got_q;
    logic       got_r, got_d, got_z, exp_z;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: empty, got size %0d expected >0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.unit == 1'b0) begin
        got_q = a_q;
        got_r = a_run;
        got_d = a_done;
        got_z = a_zero;
      end else begin
        got_q = {4'h0, b_q};
        got_r = b_run;
        got_d = b_done;
        got_z = b_zero;
      end
      exp_z = (e.q == 8'h00);
      checks++;
      assert (got_q === e.q) else begin
        errors++;
        $error("FAIL %s q: got %h expected %h", e.tag, got_q, e.q);
      end
      checks++;
      assert (got_r === e.run) else begin
        errors++;
        $error("FAIL %s running: got %b expected %b", e.tag, got_r, e.run);
      end
      checks++;
      assert (got_d === e.done) else begin
        errors++;
        $error("FAIL %s done: got %b expected %b", e.tag, got_d, e.done);
      end
      checks++;
      assert (got_z === exp_z) else begin
        errors++;
        $error("FAIL %s zero: got %b expected %b", e.tag, got_z, exp_z);
      end
    end
  endtask

  // One clocked step on one unit: drive, queue expectation, clock, compare.
  task automatic step(input bit unit, input string tag, input bit clr, input bit ld,
                      input logic [7:0] lv, input bit st, input bit sp, input bit cn,
                      input logic [7:0] eq, input logic er, input logic ed);
    if (unit == 1'b0) begin
      a_clr = clr; a_ld = ld; a_lv = lv; a_st = st; a_sp = sp; a_cn = cn;
    end else begin
      b_clr = clr; b_ld = ld; b_lv = lv[3:0]; b_st = st; b_sp = sp; b_cn = cn;
    end
    push_exp(unit, tag, eq, er, ed);
    @(posedge clk);
    #1;
    a_clr = 0; a_ld = 0; a_st = 0; a_sp = 0; a_cn = 0;
    b_clr = 0; b_ld = 0; b_st = 0; b_sp = 0; b_cn = 0;
    check_out();
  endtask

  initial begin
    a_rst = 1; a_clr = 0; a_ld = 0; a_lv = '0; a_st = 0; a_sp = 0; a_cn = 0;
    b_rst = 1; b_clr = 0; b_ld = 0; b_lv = '0; b_st = 0; b_sp = 0; b_cn = 0;
    repeat (2) @(posedge clk);
    #1;
    push_exp(0, "reset10", 8'h00, 0, 0);
    check_out();
    push_exp(1, "reset16", 8'h00, 0, 0);
    check_out();
    a_rst = 0;
    b_rst = 0;

    // Full 25-tick countdown with done pulse and DONE hold.
    step(0, "load25", 0, 1, 8'h25, 0, 0, 0, 8'h25, 0, 0);
    step(0, "idle_tick", 0, 0, 8'h00, 0, 0, 1, 8'h25, 0, 0);
    step(0, "start25", 0, 0, 8'h00, 1, 0, 0, 8'h25, 1, 0);
    for (int i = 1; i <= 25; i++) begin
      step(0, "count25", 0, 0, 8'h00, 0, 0, 1, bcd(25 - i), (i != 25), (i == 25));
    end
    step(0, "done_tick", 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
    step(0, "done_start", 0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0);

    // Borrow across digits, then start from zero.
    step(0, "load10", 0, 1, 8'h10, 0, 0, 0, 8'h10, 0, 0);
    step(0, "start10", 0, 0, 8'h00, 1, 0, 0, 8'h10, 1, 0);
    step(0, "borrow", 0, 0, 8'h00, 0, 0, 1, 8'h09, 1, 0);
    step(0, "load00", 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    step(0, "start00", 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
    step(0, "after00", 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);

    // Pause / resume, and stop winning over start.
    step(0, "load50", 0, 1, 8'h50, 0, 0, 0, 8'h50, 0, 0);
    step(0, "start50", 0, 0, 8'h00, 1, 0, 0, 8'h50, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, "run50", 0, 0, 8'h00, 0, 0, 1, bcd(50 - i), 1, 0);
    end
    step(0, "stop", 0, 0, 8'h00, 0, 1, 1, 8'h47, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, "paused", 0, 0, 8'h00, 0, 0, 1, 8'h47, 0, 0);
    end
    step(0, "resume", 0, 0, 8'h00, 1, 0, 0, 8'h47, 1, 0);
    step(0, "run47a", 0, 0, 8'h00, 0, 0, 1, 8'h46, 1, 0);
    step(0, "run47b", 0, 0, 8'h00, 0, 0, 1, 8'h45, 1, 0);
    step(0, "stop_start", 0, 0, 8'h00, 1, 1, 1, 8'h45, 0, 0);
    step(0, "pause_both", 0, 0, 8'h00, 1, 1, 0, 8'h45, 0, 0);

    // Clear beats load; saturation of out-of-range digits.
    step(0, "clr_ld", 1, 1, 8'h42, 0, 0, 0, 8'h00, 0, 0);
    step(0, "sat", 0, 1, 8'hCF, 0, 0, 0, 8'h99, 0, 0);

    // Asynchronous reset mid-RUN at 37.
    step(0, "load38", 0, 1, 8'h38, 0, 0, 0, 8'h38, 0, 0);
    step(0, "start38", 0, 0, 8'h00, 1, 0, 0, 8'h38, 1, 0);
    step(0, "to37", 0, 0, 8'h00, 0, 0, 1, 8'h37, 1, 0);
    #2;
    push_exp(0, "async_rst", 8'h00, 0, 0);
    a_rst = 1;
    #1;
    check_out();
    #1;
    a_rst = 0;
    step(0, "post_rst", 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);

    // Hex single-digit unit.
    step(1, "h_load0", 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    step(1, "h_start0", 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
    step(1, "h_after0", 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
    step(1, "h_loadF", 0, 1, 8'h0F, 0, 0, 0, 8'h0F, 0, 0);
    step(1, "h_startF", 0, 0, 8'h00, 1, 0, 0, 8'h0F, 1, 0);
    for (int i = 1; i <= 15; i++) begin
      step(1, "h_count", 0, 0, 8'h00, 0, 0, 1, 8'(15 - i), (i != 15), (i == 15));
    end
    step(1, "h_load9", 0, 1, 8'h09, 0, 0, 0, 8'h09, 0, 0);
    step(1, "h_start9", 0, 0, 8'h00, 1, 0, 0, 8'h09, 1, 0);
    step(1, "h_tick9", 0, 0, 8'h00, 0, 0, 1, 8'h08, 1, 0);
    step(1, "h_clear", 1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
    step(1, "h_restart", 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
